// File: rtl/exc_ctrl_pkg.sv
// ============================================================================
// Module      : exc_ctrl_pkg
// Description : Shared types and constants for the exception sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exc_ctrl_pkg;

    localparam logic [31:0] c_exc_vector = 32'h0040_0004;

    localparam logic [4:0] c_code_irq     = 5'd0;
    localparam logic [4:0] c_code_syscall = 5'd8;
    localparam logic [4:0] c_code_break   = 5'd9;
    localparam logic [4:0] c_code_teq     = 5'd13;

    localparam int unsigned c_st_ie      = 0;
    localparam int unsigned c_st_syscall = 1;
    localparam int unsigned c_st_break   = 2;
    localparam int unsigned c_st_teq     = 3;
    localparam int unsigned c_st_irq     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_RETURN = 2'd2,
        ST_SETTLE = 2'd3
    } exc_state_t;

    function automatic logic [31:0] cause_word(input logic [4:0] code);
        return {25'b0, code, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/exc_ctrl_irq_sync.sv
// ============================================================================
// Module      : exc_ctrl_irq_sync
// Description : Interrupt synchroniser chain feeding a sticky pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_pend <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq};
            // Taking the interrupt wins over a still-high input; a held
            // level simply re-arms the flag on the following cycle.
            if (clr)
                r_pend <= 1'b0;
            else if (r_sync[SYNC_STAGES-1])
                r_pend <= 1'b1;
        end
    end

    assign pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ============================================================================
// Module      : exc_ctrl
// Description : Trap/interrupt sequencer driving CP0 strobes and fetch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = c_exc_vector,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_req,
    input  logic        break_req,
    input  logic        teq_req,
    input  logic        eret_req,
    input  logic        irq,
    input  logic [31:0] instr_pc,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    output logic        exception,
    output logic        eret,
    output logic [31:0] cause,
    output logic [31:0] exc_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    exc_state_t  r_state, w_state_nxt;
    logic        w_irq_pend, w_irq_take;
    logic        w_take_brk, w_take_sys, w_take_teq, w_take_irq;
    logic        w_exception_nxt, w_eret_nxt, w_redirect_nxt;
    logic [31:0] w_cause_nxt, w_exc_pc_nxt, w_redirect_pc_nxt;
    logic        r_exception, r_eret, r_redirect;
    logic [31:0] r_cause, r_exc_pc, r_redirect_pc;

    exc_ctrl_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq),
        .clr  (w_irq_take),
        .pend (w_irq_pend)
    );

    assign w_take_brk = break_req   & status[c_st_ie] & status[c_st_break];
    assign w_take_sys = syscall_req & status[c_st_ie] & status[c_st_syscall];
    assign w_take_teq = teq_req     & status[c_st_ie] & status[c_st_teq];
    assign w_take_irq = w_irq_pend  & status[c_st_ie] & status[c_st_irq];

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Output values are decided here for the state being entered, so every
    // strobe leaves a flop in the same cycle the state register changes.
    always_comb begin
        w_state_nxt       = r_state;
        w_exception_nxt   = 1'b0;
        w_eret_nxt        = 1'b0;
        w_redirect_nxt    = 1'b0;
        w_cause_nxt       = '0;
        w_exc_pc_nxt      = '0;
        w_redirect_pc_nxt = '0;
        w_irq_take        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (eret_req) begin
                    w_state_nxt       = ST_RETURN;
                    w_eret_nxt        = 1'b1;
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = epc;
                end else if (w_take_brk | w_take_sys | w_take_teq | w_take_irq) begin
                    w_state_nxt       = ST_ENTER;
                    w_exception_nxt   = 1'b1;
                    w_redirect_nxt    = 1'b1;
                    w_redirect_pc_nxt = EXC_VECTOR;
                    w_exc_pc_nxt      = instr_pc;
                    if (w_take_brk)
                        w_cause_nxt = cause_word(c_code_break);
                    else if (w_take_sys)
                        w_cause_nxt = cause_word(c_code_syscall);
                    else if (w_take_teq)
                        w_cause_nxt = cause_word(c_code_teq);
                    else begin
                        w_cause_nxt = cause_word(c_code_irq);
                        w_irq_take  = 1'b1;
                    end
                end
            end
            ST_ENTER, ST_RETURN: w_state_nxt = ST_SETTLE;
            ST_SETTLE:           w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exception   <= 1'b0;
            r_eret        <= 1'b0;
            r_redirect    <= 1'b0;
            r_cause       <= '0;
            r_exc_pc      <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_exception   <= w_exception_nxt;
            r_eret        <= w_eret_nxt;
            r_redirect    <= w_redirect_nxt;
            r_cause       <= w_cause_nxt;
            r_exc_pc      <= w_exc_pc_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
        end
    end

    assign exception   = r_exception;
    assign eret        = r_eret;
    assign redirect    = r_redirect;
    assign flush       = r_redirect;
    assign cause       = r_cause;
    assign exc_pc      = r_exc_pc;
    assign redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Scoreboard bench for exc_ctrl with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_exc_ctrl;

    localparam int          S   = 2;
    localparam logic [31:0] VEC = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        syscall_req = 1'b0, break_req = 1'b0, teq_req = 1'b0;
    logic        eret_req = 1'b0, irq = 1'b0;
    logic [31:0] instr_pc = '0, status = '0, epc = '0;
    logic        exception, eret, redirect, flush;
    logic [31:0] cause, exc_pc, redirect_pc;

    always #5 clk = ~clk;

    exc_ctrl #(
        .EXC_VECTOR  (VEC),
        .SYNC_STAGES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .syscall_req (syscall_req),
        .break_req   (break_req),
        .teq_req     (teq_req),
        .eret_req    (eret_req),
        .irq         (irq),
        .instr_pc    (instr_pc),
        .status      (status),
        .epc         (epc),
        .exception   (exception),
        .eret        (eret),
        .cause       (cause),
        .exc_pc      (exc_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush)
    );

    typedef struct {
        int unsigned cyc;
        logic        exception;
        logic        eret;
        logic [31:0] cause;
        logic [31:0] exc_pc;
        logic [31:0] redirect_pc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 0;
    bit          done = 0;
    bit          final_done = 0;

    // Reference model state: cycles still locked out after an accepted
    // event, the sticky interrupt flag and the raw irq history.
    int          busy = 0;
    bit          pend = 0;
    bit          hist[S];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_step();
        exp_t        e;
        bit          req[4];
        int unsigned en_bit[4] = '{2, 1, 3, 4};
        int unsigned code[4]   = '{9, 8, 13, 0};
        bit          took_irq = 0;
        bit          found = 0;
        bit          delayed;
        if (rst) begin
            busy = 0;
            pend = 0;
            for (int i = 0; i < S; i++) hist[i] = 0;
            return;
        end
        delayed = hist[S-1];
        if (busy > 0) begin
            busy--;
        end else if (eret_req) begin
            e = '{cyc + 1, 1'b0, 1'b1, 32'h0, 32'h0, epc};
            q.push_back(e);
            busy = 2;
        end else begin
            req = '{break_req, syscall_req, teq_req, pend};
            for (int i = 0; i < 4; i++) begin
                if (!found && req[i] && status[0] && status[en_bit[i]]) begin
                    found = 1;
                    took_irq = (i == 3);
                    e = '{cyc + 1, 1'b1, 1'b0, 32'(code[i]) * 4, instr_pc, VEC};
                    q.push_back(e);
                    busy = 2;
                end
            end
        end
        pend = took_irq ? 1'b0 : (pend | delayed);
        for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = irq;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        syscall_req = 0; break_req = 0; teq_req = 0; eret_req = 0; irq = 0;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            n_checks++;
            if (exception && eret) begin
                n_fail++;
                $display("FAIL strobe_excl cyc=%0d exception=%0b eret=%0b required not both 1",
                         cyc, exception, eret);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                if (exception !== e.exception || eret !== e.eret || redirect !== 1'b1 ||
                    flush !== 1'b1 || cause !== e.cause || exc_pc !== e.exc_pc ||
                    redirect_pc !== e.redirect_pc) begin
                    n_fail++;
                    $display("FAIL strobe cyc=%0d got exc=%0b eret=%0b redir=%0b flush=%0b cause=%h pc=%h rpc=%h exp exc=%0b eret=%0b redir=1 flush=1 cause=%h pc=%h rpc=%h",
                             cyc, exception, eret, redirect, flush, cause, exc_pc, redirect_pc,
                             e.exception, e.eret, e.cause, e.exc_pc, e.redirect_pc);
                end
            end else if (exception !== 1'b0 || eret !== 1'b0 || redirect !== 1'b0 ||
                         flush !== 1'b0 || cause !== 32'h0 || exc_pc !== 32'h0 ||
                         redirect_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL quiet cyc=%0d got exc=%0b eret=%0b redir=%0b flush=%0b cause=%h pc=%h rpc=%h exp all zero",
                         cyc, exception, eret, redirect, flush, cause, exc_pc, redirect_pc);
            end
            if (done && !final_done) begin
                n_checks++;
                if (q.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain got %0d pending expectations exp 0", q.size());
                end
                final_done = 1;
            end
        end
    end

    initial begin
        rst = 1;
        tick();
        mon_en = 1;
        tick();
        rst = 0;
        idle(2);

        // 1: syscall entry
        status = 32'h1F; instr_pc = 32'h0040_0100; syscall_req = 1;
        tick(); idle(4);

        // 2: priority among traps, then eret over everything
        instr_pc = 32'h0040_0110;
        break_req = 1; syscall_req = 1; teq_req = 1;
        tick(); idle(3);
        epc = 32'h0040_0300;
        break_req = 1; syscall_req = 1; teq_req = 1; eret_req = 1;
        tick(); idle(3);

        // 3: masked by IE, then accepted
        status = 32'h1E; instr_pc = 32'h0040_0120; teq_req = 1;
        tick(); idle(3);
        status = 32'h1F; teq_req = 1;
        tick(); idle(3);

        // 4: eret redirect, syscall arriving in SETTLE is dropped
        epc = 32'h0040_0208; eret_req = 1;
        tick(); idle(1);
        syscall_req = 1;
        tick(); idle(4);

        // 5: pending interrupt waits for its enable bit
        status = 32'h0F; instr_pc = 32'h0040_0130; irq = 1;
        tick(); idle(8);
        status = 32'h1F;
        idle(8);

        // 6: reset while in ENTER
        instr_pc = 32'h0040_0140; syscall_req = 1;
        tick(); clear_reqs();
        rst = 1; tick(); rst = 0;
        idle(4);

        for (int n = 0; n < 3000; n++) begin
            syscall_req = ($urandom_range(0, 4) == 0);
            break_req   = ($urandom_range(0, 5) == 0);
            teq_req     = ($urandom_range(0, 5) == 0);
            eret_req    = ($urandom_range(0, 7) == 0);
            irq         = ($urandom_range(0, 9) == 0);
            instr_pc    = $urandom & 32'hFFFF_FFFC;
            epc         = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0)
                status = $urandom;
            else
                status = {27'h0, 5'($urandom_range(0, 31)) | 5'h01};
            rst         = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0;
        idle(6);
        done = 1;
        repeat (3) @(negedge clk);
        if (!final_done) begin
            n_fail++;
            $display("FAIL drain_timeout got no final check exp final check");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
